// File: rtl/rv32e_pkg.sv
// Shared RV32E register-file constants, load funct3 encodings and the write-back entry type.
package rv32e_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [REG_AW-1:0] regaddr_t;

    typedef struct packed {
        regaddr_t          rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of ALU write-back entries with registered ready (= not full) and empty flags.
module wb_fifo
    import rv32e_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t wdata,
    input  logic      pop,
    output wb_entry_t rdata,
    output logic      ready,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic [AW:0]    cnt_next;
    logic           full;
    logic           do_push;
    logic           do_pop;

    // Accept decisions use only the registered flags, so a pop never frees a slot for the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign cnt_next = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt   <= cnt_next;
            full  <= (cnt_next == (AW+1)'(DEPTH));
            ready <= (cnt_next != (AW+1)'(DEPTH));
            empty <= (cnt_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/reg_writeback.sv
// RV32E register-file write side: LSU-priority arbitration of load and buffered ALU results,
// load data formatting, registered write port and pending-destination scoreboard.
module reg_writeback
    import rv32e_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int NUM_REGS       = rv32e_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [4:0]          alu_rd_i,
    input  logic [31:0]         alu_data_i,
    input  logic                lsu_valid_i,
    input  logic [4:0]          lsu_rd_i,
    input  logic [2:0]          lsu_funct3_i,
    input  logic [1:0]          lsu_byte_off_i,
    input  logic [31:0]         lsu_data_i,
    input  logic                issue_valid_i,
    input  logic [4:0]          issue_rd_i,
    output logic                write_enable_o,
    output logic [4:0]          write_address_o,
    output logic [31:0]         write_data_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                err_o
);

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'h0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'h0, h};
            F3_LW:   return raw;
            default: return 32'h0;
        endcase
    endfunction

    wb_entry_t           fifo_head;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                commit_valid;
    regaddr_t            commit_rd;
    logic [31:0]         commit_data;
    logic                f3_bad;
    logic                we_next;
    logic                err_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (alu_valid_i && alu_ready_o),
        .wdata ('{rd: alu_rd_i, data: alu_data_i}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .ready (alu_ready_o),
        .empty (fifo_empty)
    );

    // Loads can never be stalled, so they always win the single write port.
    always_comb begin
        fifo_pop     = 1'b0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_data  = '0;
        f3_bad       = 1'b0;
        if (lsu_valid_i) begin
            commit_valid = 1'b1;
            commit_rd    = lsu_rd_i;
            commit_data  = fmt_load(lsu_funct3_i, lsu_byte_off_i, lsu_data_i);
            f3_bad       = !f3_legal(lsu_funct3_i);
        end else if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            commit_valid = 1'b1;
            commit_rd    = fifo_head.rd;
            commit_data  = fifo_head.data;
        end
    end

    assign we_next  = commit_valid && !commit_rd[4] && (commit_rd != '0);
    assign err_next = commit_valid && (commit_rd[4] || f3_bad);
    assign set_mask = (issue_valid_i && !issue_rd_i[4] && (issue_rd_i != '0))
                      ? (NUM_REGS'(1) << issue_rd_i[3:0]) : '0;
    assign clr_mask = we_next ? (NUM_REGS'(1) << commit_rd[3:0]) : '0;

    // Write-port and scoreboard registers; a same-cycle issue re-sets the bit a commit clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable_o  <= 1'b0;
            write_address_o <= '0;
            write_data_o    <= '0;
            err_o           <= 1'b0;
            pending_o       <= '0;
        end else begin
            write_enable_o  <= we_next;
            write_address_o <= commit_rd;
            write_data_o    <= commit_data;
            err_o           <= err_next;
            pending_o       <= (pending_o & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with an expected-write queue checked on every register write.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byte_off_i;
    logic [31:0] lsu_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        write_enable_o;
    logic [4:0]  write_address_o;
    logic [31:0] write_data_o;
    logic [15:0] pending_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    reg_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid_i     (alu_valid_i),
        .alu_ready_o     (alu_ready_o),
        .alu_rd_i        (alu_rd_i),
        .alu_data_i      (alu_data_i),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_rd_i        (lsu_rd_i),
        .lsu_funct3_i    (lsu_funct3_i),
        .lsu_byte_off_i  (lsu_byte_off_i),
        .lsu_data_i      (lsu_data_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_i      (issue_rd_i),
        .write_enable_o  (write_enable_o),
        .write_address_o (write_address_o),
        .write_data_o    (write_data_o),
        .pending_o       (pending_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_write(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] raw);
        lsu_valid_i    = v;
        lsu_rd_i       = rd;
        lsu_funct3_i   = f3;
        lsu_byte_off_i = off;
        lsu_data_i     = raw;
    endtask

    // Every register write must be the next one the stimulus predicted.
    always @(negedge clk) begin
        if (write_enable_o) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected observed=%h:%h expected=none", write_address_o, write_data_o);
            end else begin
                e = exp_q.pop_front();
                assert ({write_address_o, write_data_o} === {e.addr, e.data})
                else begin
                    bad++;
                    $error("FAIL sb_write observed=%h:%h expected=%h:%h",
                           write_address_o, write_data_o, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        int sent;
        logic acc;
        reset         = 1'b1;
        alu_valid_i   = 1'b0;
        alu_rd_i      = '0;
        alu_data_i    = '0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        repeat (3) tick();
        chk("rst_we", write_enable_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_err", err_o, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", alu_ready_o, 1);

        // ALU write latency of two cycles and scoreboard clear
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        tick();
        issue_valid_i = 1'b0;
        chk("t1_pending_set", pending_o, 16'h0020);
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        exp_write(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid_i = 1'b0;
        chk("t1_we_n1", write_enable_o, 0);
        tick();
        chk("t1_we_n2", write_enable_o, 1);
        chk("t1_addr", write_address_o, 5);
        chk("t1_data", write_data_o, 32'hDEADBEEF);
        chk("t1_pending_clr", pending_o, 0);

        // load formatting
        lsu(1'b1, 5'd3, 3'b000, 2'd2, 32'h0080_0000); exp_write(5'd3, 32'hFFFFFF80);
        tick();
        chk("t2_lb", write_data_o, 32'hFFFFFF80);
        lsu(1'b1, 5'd3, 3'b100, 2'd2, 32'h0080_0000); exp_write(5'd3, 32'h00000080);
        tick();
        chk("t2_lbu", write_data_o, 32'h00000080);
        lsu(1'b1, 5'd6, 3'b101, 2'd3, 32'hBEEF_1234); exp_write(5'd6, 32'h0000BEEF);
        tick();
        chk("t2_lhu", write_data_o, 32'h0000BEEF);
        lsu(1'b1, 5'd2, 3'b001, 2'd1, 32'h1111_8001); exp_write(5'd2, 32'hFFFF8001);
        tick();
        chk("t2_lh", write_data_o, 32'hFFFF8001);
        lsu(1'b1, 5'd9, 3'b010, 2'd3, 32'h1234_5678); exp_write(5'd9, 32'h12345678);
        tick();
        chk("t2_lw", write_data_o, 32'h12345678);
        chk("t2_lw_we", write_enable_o, 1);
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        tick();
        chk("t2_idle_we", write_enable_o, 0);

        // LSU priority over three ALU pushes with backpressure
        for (int i = 1; i <= 4; i++) exp_write(5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) exp_write(5'(10 + i), 32'hA0 + 32'(i));
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) lsu(1'b1, 5'(i + 1), 3'b010, 2'd0, 32'h100 + 32'(i + 1));
            else       lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
            alu_valid_i = (sent < 3);
            alu_rd_i    = 5'(10 + sent);
            alu_data_i  = 32'hA0 + 32'(sent);
            acc = alu_valid_i && alu_ready_o;
            tick();
            if (acc) sent++;
            if (i == 1) chk("t3_ready_low", alu_ready_o, 0);
        end
        alu_valid_i = 1'b0;
        chk("t3_all_pushed", sent, 3);
        chk("t3_drained", exp_q.size(), 0);

        // scoreboard set wins over same-cycle clear
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        lsu(1'b1, 5'd7, 3'b010, 2'd0, 32'h77); exp_write(5'd7, 32'h77);
        tick();
        issue_valid_i = 1'b0;
        chk("t4_set_wins", pending_o, 16'h0080);
        lsu(1'b1, 5'd7, 3'b010, 2'd0, 32'h78); exp_write(5'd7, 32'h78);
        tick();
        chk("t4_clear", pending_o, 16'h0000);

        // rd=0, rd>=16 and illegal funct3
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1234;
        tick();
        alu_valid_i = 1'b0;
        tick();
        chk("t5_rd0_we", write_enable_o, 0);
        chk("t5_rd0_err", err_o, 0);
        lsu(1'b1, 5'd17, 3'b010, 2'd0, 32'h55);
        tick();
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        chk("t5_rd17_err", err_o, 1);
        chk("t5_rd17_we", write_enable_o, 0);
        tick();
        chk("t5_err_once", err_o, 0);
        lsu(1'b1, 5'd8, 3'b011, 2'd0, 32'hFFFF_FFFF); exp_write(5'd8, 32'h0);
        tick();
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        chk("t5_f3_err", err_o, 1);
        chk("t5_f3_data", write_data_o, 0);
        tick();
        chk("t5_f3_err_once", err_o, 0);

        // reset with full FIFO discards everything
        issue_valid_i = 1'b1; issue_rd_i = 5'd12;
        lsu(1'b1, 5'd9, 3'b010, 2'd0, 32'h91); exp_write(5'd9, 32'h91);
        alu_valid_i = 1'b1; alu_rd_i = 5'd13; alu_data_i = 32'hC13;
        tick();
        issue_valid_i = 1'b0;
        lsu(1'b1, 5'd9, 3'b010, 2'd0, 32'h92); exp_write(5'd9, 32'h92);
        alu_rd_i = 5'd14; alu_data_i = 32'hC14;
        tick();
        alu_valid_i = 1'b0;
        chk("t6_full", alu_ready_o, 0);
        reset = 1'b1;
        lsu(1'b1, 5'd4, 3'b010, 2'd0, 32'h44);
        tick();
        chk("t6_rst_we", write_enable_o, 0);
        chk("t6_rst_pending", pending_o, 0);
        reset = 1'b0;
        lsu(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
        tick();
        chk("t6_ready", alu_ready_o, 1);
        repeat (3) tick();
        chk("t6_no_stale", exp_q.size(), 0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd15; alu_data_i = 32'hF15;
        exp_write(5'd15, 32'hF15);
        tick();
        alu_valid_i = 1'b0;
        tick();
        chk("t6_fresh_we", write_enable_o, 1);
        chk("t6_fresh_data", write_data_o, 32'hF15);
        tick();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
